// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and FSM state encoding shared by the CORDIC rotator.
//   ITER     : default number of micro-rotations per operation
//   CORDIC_K : inverse CORDIC gain 0.607253 in Q16.16, used as the start x
//   HALF_PI  : pi/2 in Q16.16, the clamp limit for the input angle
package cordic_pkg;

   localparam int ITER = 16;
   localparam logic signed [31:0] CORDIC_K = 32'sd39797;
   localparam logic signed [31:0] HALF_PI  = 32'sd102944;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/cordic_rotator_lookup_table.sv
// lookup_table: combinational arctangent table, atan(2^-index) in Q16.16.
//   index    : table index (entries beyond the useful range return 0)
//   atan_val : signed Q16.16 angle in radians
module lookup_table (
   input  logic [4:0]         index,
   output logic signed [31:0] atan_val
);

   // Rounded atan(2^-i) * 65536 for each index.
   always_comb begin
      case (index)
         5'd0:    atan_val = 32'sd51472;
         5'd1:    atan_val = 32'sd30386;
         5'd2:    atan_val = 32'sd16055;
         5'd3:    atan_val = 32'sd8150;
         5'd4:    atan_val = 32'sd4091;
         5'd5:    atan_val = 32'sd2047;
         5'd6:    atan_val = 32'sd1024;
         5'd7:    atan_val = 32'sd512;
         5'd8:    atan_val = 32'sd256;
         5'd9:    atan_val = 32'sd128;
         5'd10:   atan_val = 32'sd64;
         5'd11:   atan_val = 32'sd32;
         5'd12:   atan_val = 32'sd16;
         5'd13:   atan_val = 32'sd8;
         5'd14:   atan_val = 32'sd4;
         5'd15:   atan_val = 32'sd2;
         5'd16:   atan_val = 32'sd1;
         default: atan_val = 32'sd0;
      endcase
   end

endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC producing cos/sin of an angle,
// one micro-rotation per clock.
//   clk      : clock, all state on the rising edge
//   rst      : synchronous active-high reset
//   start    : begin an operation (honoured only in IDLE)
//   angle_in : signed Q16.16 angle in radians, clamped to +/-pi/2
//   busy     : high during every RUN cycle
//   done     : one-cycle pulse when cos_out/sin_out are updated
//   cos_out  : signed Q16.16 cosine of the captured angle
//   sin_out  : signed Q16.16 sine of the captured angle
module cordic_rotator
   import cordic_pkg::*;
#(
   parameter int ITER = cordic_pkg::ITER,
   parameter int W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] angle_in,
   output logic                busy,
   output logic                done,
   output logic signed [W-1:0] cos_out,
   output logic signed [W-1:0] sin_out
);

   localparam int          IW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [IW-1:0] LAST = IW'(ITER - 1);

   state_t                state_r, state_nx_s;
   logic signed [W-1:0]   x_r, y_r, z_r;
   logic [IW-1:0]         i_r;
   logic signed [W-1:0]   x_nx_s, y_nx_s, z_nx_s;
   logic signed [W-1:0]   xs_s, ys_s;
   logic signed [31:0]    atan_s;
   logic signed [W-1:0]   atan_w_s;
   logic                  done_r;
   logic signed [W-1:0]   cos_r, sin_r;

   // Clamp the requested angle into the CORDIC convergence range.
   function automatic logic signed [W-1:0] sat_angle(input logic signed [W-1:0] a);
      logic signed [W-1:0] lim;
      lim = W'(HALF_PI);
      if (a > lim) begin
         return lim;
      end else if (a < -lim) begin
         return -lim;
      end else begin
         return a;
      end
   endfunction

   lookup_table u_atan (
      .index    (5'(i_r)),
      .atan_val (atan_s)
   );

   assign atan_w_s = W'(atan_s);

   // One micro-rotation; direction follows the sign of the residual angle.
   always_comb begin
      xs_s = x_r >>> i_r;
      ys_s = y_r >>> i_r;
      if (!z_r[W-1]) begin
         x_nx_s = x_r - ys_s;
         y_nx_s = y_r + xs_s;
         z_nx_s = z_r - atan_w_s;
      end else begin
         x_nx_s = x_r + ys_s;
         y_nx_s = y_r - xs_s;
         z_nx_s = z_r + atan_w_s;
      end
   end

   // Next-state logic for the IDLE/RUN controller.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (i_r == LAST) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = RUN;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Datapath, iteration counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r    <= {W{1'b0}};
         y_r    <= {W{1'b0}};
         z_r    <= {W{1'b0}};
         i_r    <= {IW{1'b0}};
         done_r <= 1'b0;
         cos_r  <= {W{1'b0}};
         sin_r  <= {W{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  x_r <= W'(CORDIC_K);
                  y_r <= {W{1'b0}};
                  z_r <= sat_angle(angle_in);
                  i_r <= {IW{1'b0}};
               end
            end
            RUN: begin
               x_r <= x_nx_s;
               y_r <= y_nx_s;
               z_r <= z_nx_s;
               if (i_r == LAST) begin
                  // Results include the final micro-rotation.
                  cos_r  <= x_nx_s;
                  sin_r  <= y_nx_s;
                  done_r <= 1'b1;
                  i_r    <= {IW{1'b0}};
               end else begin
                  i_r <= i_r + IW'(1);
               end
            end
            default: begin
               i_r <= {IW{1'b0}};
            end
         endcase
      end
   end

   assign busy    = (state_r == RUN);
   assign done    = done_r;
   assign cos_out = cos_r;
   assign sin_out = sin_r;

endmodule
